// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
// Sequencer for the matrix-multiplier MAC datapath. For an N x N x N product it
// walks (row, col, k), clears the accumulator before each output element,
// pulses the partial-product enable once per k term, captures the sum in the
// final-data register and offers each element downstream over valid/ready.
// Overflow reported by the final-data register is collected per run.
//
// Optional build macro: MATMUL_OVF_ABORT_EN
//   defined   : an overflowing element ends the run early (aborted = 1)
//   undefined : overflow is only recorded in ovf_sticky, aborted is 0
//
// All outputs come straight from flops: the strobes are decoded from the next
// state and registered, so they are Moore outputs of the current state.
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic [IDX_W-1:0] k_idx,
    output logic             clr_acc,
    output logic             en_PPReg,
    output logic             en_FDReg,
    input  logic             resultIsInvalid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf_sticky,
    output logic             aborted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_MAC   = 3'd2,
        S_STORE = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Highest legal index value and the increment step, sized to the index.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(0);

    state_t           state_r;
    state_t           state_nxt_s;

    logic [IDX_W-1:0] row_r;
    logic [IDX_W-1:0] col_r;
    logic [IDX_W-1:0] k_r;
    logic [IDX_W-1:0] row_nxt_s;
    logic [IDX_W-1:0] col_nxt_s;
    logic [IDX_W-1:0] k_nxt_s;

    logic             ovf_r;
    logic             abt_r;
    logic             ovf_nxt_s;
    logic             abt_nxt_s;

    logic             busy_r;
    logic             done_r;
    logic             clr_r;
    logic             pp_r;
    logic             fd_r;
    logic             valid_r;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             clr_nxt_s;
    logic             pp_nxt_s;
    logic             fd_nxt_s;
    logic             valid_nxt_s;

    logic             k_last_s;
    logic             col_last_s;
    logic             row_last_s;
    logic             elem_last_s;
    logic             handshake_s;
    logic             abort_req_s;

    assign k_last_s    = (k_r == LAST_IDX);
    assign col_last_s  = (col_r == LAST_IDX);
    assign row_last_s  = (row_r == LAST_IDX);
    assign elem_last_s = col_last_s & row_last_s;
    assign handshake_s = (state_r == S_OUT) & out_ready;

`ifdef MATMUL_OVF_ABORT_EN
    assign abort_req_s = resultIsInvalid;
`else
    assign abort_req_s = 1'b0;
`endif

    // State register; reset abandons any run in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode for the element sequence CLEAR -> MAC*N -> STORE -> OUT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_CLEAR;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_nxt_s = S_MAC;
            end
            S_MAC: begin
                if (k_last_s) begin
                    state_nxt_s = S_STORE;
                end else begin
                    state_nxt_s = S_MAC;
                end
            end
            S_STORE: begin
                state_nxt_s = S_OUT;
            end
            S_OUT: begin
                if (!out_ready) begin
                    state_nxt_s = S_OUT;
                end else if (elem_last_s || abort_req_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_CLEAR;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Index walk: k steps inside MAC, (row, col) advance only on an OUT handshake.
    always_comb begin
        row_nxt_s = row_r;
        col_nxt_s = col_r;
        k_nxt_s   = k_r;
        case (state_r)
            S_IDLE: begin
                row_nxt_s = ZERO_IDX;
                col_nxt_s = ZERO_IDX;
                k_nxt_s   = ZERO_IDX;
            end
            S_MAC: begin
                if (k_last_s) begin
                    k_nxt_s = ZERO_IDX;
                end else begin
                    k_nxt_s = k_r + ONE_IDX;
                end
            end
            S_OUT: begin
                if (!out_ready) begin
                    row_nxt_s = row_r;
                    col_nxt_s = col_r;
                end else if (elem_last_s || abort_req_s) begin
                    row_nxt_s = ZERO_IDX;
                    col_nxt_s = ZERO_IDX;
                    k_nxt_s   = ZERO_IDX;
                end else if (col_last_s) begin
                    col_nxt_s = ZERO_IDX;
                    row_nxt_s = row_r + ONE_IDX;
                end else begin
                    col_nxt_s = col_r + ONE_IDX;
                end
            end
            S_DONE: begin
                row_nxt_s = ZERO_IDX;
                col_nxt_s = ZERO_IDX;
                k_nxt_s   = ZERO_IDX;
            end
            default: begin
                row_nxt_s = row_r;
                col_nxt_s = col_r;
                k_nxt_s   = k_r;
            end
        endcase
    end

    // Run flags: cleared on an accepted start, overflow collected on handshakes.
    always_comb begin
        ovf_nxt_s = ovf_r;
        abt_nxt_s = abt_r;
        if ((state_r == S_IDLE) && start) begin
            ovf_nxt_s = 1'b0;
            abt_nxt_s = 1'b0;
        end else if (handshake_s) begin
            ovf_nxt_s = ovf_r | resultIsInvalid;
            abt_nxt_s = abt_r | abort_req_s;
        end else begin
            ovf_nxt_s = ovf_r;
            abt_nxt_s = abt_r;
        end
    end

    // Index and run-flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_r <= ZERO_IDX;
            col_r <= ZERO_IDX;
            k_r   <= ZERO_IDX;
            ovf_r <= 1'b0;
            abt_r <= 1'b0;
        end else begin
            row_r <= row_nxt_s;
            col_r <= col_nxt_s;
            k_r   <= k_nxt_s;
            ovf_r <= ovf_nxt_s;
            abt_r <= abt_nxt_s;
        end
    end

    // Output decode from the next state, so the registered strobes track the state.
    always_comb begin
        busy_nxt_s  = 1'b1;
        done_nxt_s  = 1'b0;
        clr_nxt_s   = 1'b0;
        pp_nxt_s    = 1'b0;
        fd_nxt_s    = 1'b0;
        valid_nxt_s = 1'b0;
        case (state_nxt_s)
            S_IDLE:  busy_nxt_s  = 1'b0;
            S_CLEAR: clr_nxt_s   = 1'b1;
            S_MAC:   pp_nxt_s    = 1'b1;
            S_STORE: fd_nxt_s    = 1'b1;
            S_OUT:   valid_nxt_s = 1'b1;
            S_DONE:  done_nxt_s  = 1'b1;
            default: busy_nxt_s  = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            clr_r   <= 1'b0;
            pp_r    <= 1'b0;
            fd_r    <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            clr_r   <= clr_nxt_s;
            pp_r    <= pp_nxt_s;
            fd_r    <= fd_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign clr_acc    = clr_r;
    assign en_PPReg   = pp_r;
    assign en_FDReg   = fd_r;
    assign out_valid  = valid_r;
    assign row_idx    = row_r;
    assign col_idx    = col_r;
    assign k_idx      = k_r;
    assign ovf_sticky = ovf_r;
    assign aborted    = abt_r;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_seq_ctrl
// Directed bench for matmul_seq_ctrl with three instances (N = 2, 4, 1).
// Every cycle of each run is compared against the expected output vector
// {busy,done,clr_acc,en_PPReg,en_FDReg,out_valid,ovf_sticky,aborted,row,col,k}.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

    logic clk;
    logic reset_n;

    logic start2, ready2, rii2;
    logic start4, ready4, rii4;
    logic start1, ready1, rii1;

    logic busy2, done2, clr2, pp2, fd2, valid2, ovf2, abt2;
    logic busy4, done4, clr4, pp4, fd4, valid4, ovf4, abt4;
    logic busy1, done1, clr1, pp1, fd1, valid1, ovf1, abt1;
    logic [1:0] row2, col2, k2;
    logic [1:0] row4, col4, k4;
    logic [1:0] row1, col1, k1;

    int n_vec;
    int n_err;

    matmul_seq_ctrl #(.N(2), .IDX_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
        .row_idx(row2), .col_idx(col2), .k_idx(k2), .clr_acc(clr2),
        .en_PPReg(pp2), .en_FDReg(fd2), .resultIsInvalid(rii2),
        .out_valid(valid2), .out_ready(ready2), .ovf_sticky(ovf2), .aborted(abt2)
    );

    matmul_seq_ctrl #(.N(4), .IDX_W(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .busy(busy4), .done(done4),
        .row_idx(row4), .col_idx(col4), .k_idx(k4), .clr_acc(clr4),
        .en_PPReg(pp4), .en_FDReg(fd4), .resultIsInvalid(rii4),
        .out_valid(valid4), .out_ready(ready4), .ovf_sticky(ovf4), .aborted(abt4)
    );

    matmul_seq_ctrl #(.N(1), .IDX_W(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
        .row_idx(row1), .col_idx(col1), .k_idx(k1), .clr_acc(clr1),
        .en_PPReg(pp1), .en_FDReg(fd1), .resultIsInvalid(rii1),
        .out_valid(valid1), .out_ready(ready1), .ovf_sticky(ovf1), .aborted(abt1)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [13:0] ev(input bit b, input bit d, input bit c,
                                       input bit p, input bit f, input bit v,
                                       input bit o, input bit a,
                                       input int r, input int cl, input int k);
        ev = {b, d, c, p, f, v, o, a, 2'(r), 2'(cl), 2'(k)};
    endfunction

    function automatic logic [13:0] get_obs(input int sel);
        case (sel)
            0:       get_obs = {busy2, done2, clr2, pp2, fd2, valid2, ovf2, abt2, row2, col2, k2};
            1:       get_obs = {busy4, done4, clr4, pp4, fd4, valid4, ovf4, abt4, row4, col4, k4};
            default: get_obs = {busy1, done1, clr1, pp1, fd1, valid1, ovf1, abt1, row1, col1, k1};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic rd, input logic ri);
        case (sel)
            0:       begin start2 = st; ready2 = rd; rii2 = ri; end
            1:       begin start4 = st; ready4 = rd; rii4 = ri; end
            default: begin start1 = st; ready1 = rd; rii1 = ri; end
        endcase
    endtask

    // One run from IDLE. stall_e/stall_len: hold out_ready low at that element.
    // ovf_e: element whose handshake reports overflow. spur: start high during
    // OUT/DONE. hold: start held high through the trailing IDLE. rst_e: pull
    // reset during the first MAC cycle of that element. -1 disables an option.
    task automatic run(input int sel, input int n, input int stall_e, input int stall_len,
                       input int ovf_e, input bit spur, input bit hold, input int rst_e);
        bit ovf;
        bit abt;
        bit stop;
        int r;
        int c;
        ovf  = 1'b0;
        abt  = 1'b0;
        stop = 1'b0;
        drive(sel, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        for (int e = 0; e < n * n && !stop; e++) begin
            r = e / n;
            c = e % n;
            chk("clear", get_obs(sel), ev(1, 0, 1, 0, 0, 0, ovf, abt, r, c, 0));
            drive(sel, hold, 1'b1, 1'b0);
            @(negedge clk);
            for (int k = 0; k < n; k++) begin
                chk("mac", get_obs(sel), ev(1, 0, 0, 1, 0, 0, ovf, abt, r, c, k));
                if (e == rst_e && k == 0) begin
                    drive(sel, 1'b0, 1'b1, 1'b0);
                    #2 reset_n = 1'b0;
                    #1 chk("rst_async", get_obs(sel), 14'd0);
                    @(negedge clk);
                    chk("rst_hold", get_obs(sel), 14'd0);
                    reset_n = 1'b1;
                    @(negedge clk);
                    chk("rst_idle", get_obs(sel), 14'd0);
                    @(negedge clk);
                    chk("rst_idle2", get_obs(sel), 14'd0);
                    return;
                end
                @(negedge clk);
            end
            chk("store", get_obs(sel), ev(1, 0, 0, 0, 1, 0, ovf, abt, r, c, 0));
            @(negedge clk);
            if (e == stall_e) begin
                for (int s = 0; s < stall_len; s++) begin
                    drive(sel, hold | spur, 1'b0, 1'b0);
                    chk("stall", get_obs(sel), ev(1, 0, 0, 0, 0, 1, ovf, abt, r, c, 0));
                    @(negedge clk);
                end
            end
            drive(sel, hold | spur, 1'b1, (e == ovf_e));
            chk("out", get_obs(sel), ev(1, 0, 0, 0, 0, 1, ovf, abt, r, c, 0));
            @(negedge clk);
            if (e == ovf_e) begin
                ovf = 1'b1;
`ifdef MATMUL_OVF_ABORT_EN
                abt  = 1'b1;
                stop = 1'b1;
`endif
            end
            drive(sel, hold, 1'b1, 1'b0);
        end
        chk("done", get_obs(sel), ev(1, 1, 0, 0, 0, 0, ovf, abt, 0, 0, 0));
        drive(sel, hold | spur, 1'b1, 1'b0);
        @(negedge clk);
        chk("idle", get_obs(sel), ev(0, 0, 0, 0, 0, 0, ovf, abt, 0, 0, 0));
        drive(sel, hold, 1'b1, 1'b0);
        if (!hold) begin
            @(negedge clk);
            chk("idle2", get_obs(sel), ev(0, 0, 0, 0, 0, 0, ovf, abt, 0, 0, 0));
        end
    endtask

    // Directed sequence.
    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_n2", get_obs(0), 14'd0);
        chk("reset_n4", get_obs(1), 14'd0);
        chk("reset_n1", get_obs(2), 14'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset", get_obs(0), 14'd0);

        // N=2 plain run, then a 5-cycle stall at element (0,1).
        run(0, 2, -1, 0, -1, 1'b0, 1'b0, -1);
        run(0, 2,  1, 5, -1, 1'b0, 1'b0, -1);

        // N=4 with overflow at element (2,3).
        run(1, 4, -1, 0, 11, 1'b0, 1'b0, -1);

        // N=2 reset during MAC of element (1,0), then a full run.
        run(0, 2, -1, 0, -1, 1'b0, 1'b0, 2);
        run(0, 2, -1, 0, -1, 1'b0, 1'b0, -1);

        // Spurious start in OUT/DONE, then start held across runs clearing ovf_sticky.
        run(0, 2, -1, 0,  0, 1'b1, 1'b0, -1);
        run(0, 2, -1, 0,  3, 1'b0, 1'b1, -1);
        run(0, 2, -1, 0, -1, 1'b0, 1'b0, -1);

        // N=1 single element.
        run(2, 1, -1, 0, -1, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer for the matrix-multiplier MAC datapath.
- Drives the partial-product register enable (en_PPReg) and the final-data register enable (en_FDReg).
- Walks the row/column/k indices for an N x N x N product, clears the accumulator per output element, and hands each finished element to downstream logic over a valid/ready handshake.
- Collects the final-data register's overflow flag per run.

Parameters:
- N, 4, matrix dimension; 1 <= N <= 2**IDX_W.
- IDX_W, 2, width of row/col/k index outputs.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- row_idx  out  IDX_W  current output row i.
- col_idx  out  IDX_W  current output column j.
- k_idx  out  IDX_W  current inner-product term k; selects A[i][k] and B[k][j].
- clr_acc  out  1  clears the accumulator / partial-product register (cin forced 0).
- en_PPReg  out  1  partial-product register enable; high for one cycle per k term.
- en_FDReg  out  1  final-data register enable; captures the accumulated sum.
- resultIsInvalid  in  1  overflow flag from the final-data register.
- out_valid  out  1  C[row_idx][col_idx] is present at the final-data register output.
- out_ready  in  1  downstream accepts the element.
- ovf_sticky  out  1  set if any element of the run overflowed.
- aborted  out  1  run ended early on overflow; tied 0 unless the macro below is defined.

Behaviour:
- Reset (async, reset_n=0): state=IDLE.
  - All outputs are 0: busy, done, clr_acc, en_PPReg, en_FDReg, out_valid, ovf_sticky, aborted, and all indices.
  - Reset asserted mid-run abandons the run immediately. No done pulse.
- Strobes clr_acc, en_PPReg and en_FDReg are Moore outputs of the state. They are mutually exclusive.
- States:
  - IDLE: waits for start. On start=1: state -> CLEAR; indices are zeroed; ovf_sticky and aborted are cleared.
  - CLEAR: 1 cycle, clr_acc=1. -> MAC with k_idx=0.
  - MAC: N cycles, en_PPReg=1 every cycle, k_idx counts 0..N-1. On k_idx=N-1: -> STORE and k_idx is reset to 0.
  - STORE: 1 cycle, en_FDReg=1. -> OUT.
  - OUT: out_valid=1. row_idx, col_idx and the final-data register are held stable until out_ready=1.
    - On handshake (out_valid & out_ready): ovf_sticky |= resultIsInvalid.
    - If col_idx=N-1 and row_idx=N-1: -> DONE.
    - Otherwise advance col_idx, wrapping N-1 -> 0 with row_idx+1, then -> CLEAR.
  - DONE: 1 cycle, done=1, busy=1. -> IDLE. Indices return to 0.
- start is ignored outside IDLE. start held high continuously causes back-to-back runs with one IDLE cycle between them.
- Stall: with out_ready=0, OUT persists indefinitely. No enable is asserted while stalled.
- Cycles per element = N+3 when out_ready=1. Run length with no stalls is N*N*(N+3) cycles, plus 1 DONE cycle.
- N=1: MAC lasts 1 cycle; the single element goes directly to DONE after its handshake.
- Index counters are not allowed to reach N. Values >= N never appear on the outputs.

Optional Feature:
- Macro: MATMUL_OVF_ABORT_EN.
- Defined: a handshake in OUT with resultIsInvalid=1 sets ovf_sticky and aborted. State then goes to DONE regardless of indices. The remaining elements are not computed. aborted holds until the next start or reset.
- Undefined: overflow only sets ovf_sticky and the run completes normally. aborted is constant 0.

Test Plan:
- N=2, start pulsed 1 cycle, out_ready=1 -> clr_acc, en_PPReg x2, en_FDReg and out_valid repeat 4 times. (row,col) order is (0,0),(0,1),(1,0),(1,1). done pulses in the 21st cycle after the start edge. busy falls the cycle after.
- N=2, out_ready=0 for 5 cycles at element (0,1) -> out_valid held with indices stable. en_PPReg and en_FDReg stay 0. Run completes 5 cycles later than the no-stall case.
- N=4, resultIsInvalid=1 only at element (2,3) handshake -> ovf_sticky=1 from the next cycle. All 16 elements are delivered, done after 112+ cycles, aborted=0. With MATMUL_OVF_ABORT_EN: done follows the (2,3) handshake and aborted=1.
- reset_n pulled low during MAC of element (1,0) -> all outputs 0 asynchronously, state=IDLE, no done pulse. A new start runs a full run from (0,0).
- start asserted during OUT and during DONE -> ignored, no restart. Held high through IDLE -> second run begins and ovf_sticky is cleared.
- N=1 -> the sequence is clr_acc, en_PPReg, en_FDReg, out_valid, then done 5 cycles after start.
